tcache_refill: RTL

- Miss-refill engine directly downstream of the texture cache tag-match stage.
- Accepts one line-aligned miss address and issues a single TileLink-UH Get for the 128-byte line on the A channel.
- Streams the 32 returning 32-bit D beats into the cache data RAM as word writes, then pulses completion carrying the set index, tag and error status for the tag/valid update.

---
 rtl/tcache_pkg.sv | 25 ++
 rtl/tcache_refill_if.sv | 43 ++++
 rtl/tcache_refill.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/tcache_pkg.sv
// Shared texture-cache definitions: TileLink constants, line geometry and
// the refill engine state encoding.
package tcache_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned LINE_WORDS = 32;
  localparam int unsigned LINE_OFF_W = 7;
  localparam int unsigned INDEX_W    = 4;
  localparam int unsigned TAG_W      = 21;
  localparam int unsigned CNT_W      = $clog2(LINE_WORDS);
  localparam int unsigned PERF_W     = 32;

  localparam logic [2:0] TL_GET             = 3'd4;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;
  localparam logic [3:0] LINE_SIZE_LOG2     = 4'd7;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } state_e;

endpackage

// File: rtl/tcache_refill_if.sv
// TileLink-UH A/D channel bundle between the refill engine (master) and
// the memory fabric (slave).
interface tcache_refill_if;
  import tcache_pkg::*;

  logic [2:0]        tcache_a_opcode;
  logic [2:0]        tcache_a_param;
  logic [3:0]        tcache_a_size;
  logic [ADDR_W-1:0] tcache_a_address;
  logic [3:0]        tcache_a_mask;
  logic [DATA_W-1:0] tcache_a_data;
  logic              tcache_a_corrupt;
  logic              tcache_a_valid;
  logic              tcache_a_ready;

  logic [2:0]        tcache_d_opcode;
  logic [1:0]        tcache_d_param;
  logic [3:0]        tcache_d_size;
  logic              tcache_d_denied;
  logic [DATA_W-1:0] tcache_d_data;
  logic              tcache_d_corrupt;
  logic              tcache_d_valid;
  logic              tcache_d_ready;

  modport master (
    output tcache_a_opcode, tcache_a_param, tcache_a_size, tcache_a_address,
           tcache_a_mask, tcache_a_data, tcache_a_corrupt, tcache_a_valid,
    input  tcache_a_ready,
    input  tcache_d_opcode, tcache_d_param, tcache_d_size, tcache_d_denied,
           tcache_d_data, tcache_d_corrupt, tcache_d_valid,
    output tcache_d_ready
  );

  modport slave (
    input  tcache_a_opcode, tcache_a_param, tcache_a_size, tcache_a_address,
           tcache_a_mask, tcache_a_data, tcache_a_corrupt, tcache_a_valid,
    output tcache_a_ready,
    output tcache_d_opcode, tcache_d_param, tcache_d_size, tcache_d_denied,
           tcache_d_data, tcache_d_corrupt, tcache_d_valid,
    input  tcache_d_ready
  );

endinterface

// File: rtl/tcache_refill.sv
// Texture cache miss-refill engine: one TileLink Get per 128-byte line, 32 word
// writes into the data RAM, then a done pulse. Optional TCACHE_REFILL_PERF_EN adds perf counters.
module tcache_refill
  import tcache_pkg::*;
(
  input  logic               core_clock_i,
  input  logic               core_reset_n_i,
  input  logic               miss_valid_i,
  output logic               miss_ready_o,
  input  logic [ADDR_W-1:0]  miss_addr_i,
  output logic               fill_we_o,
  output logic [INDEX_W-1:0] fill_set_o,
  output logic [CNT_W-1:0]   fill_word_o,
  output logic [DATA_W-1:0]  fill_data_o,
  output logic               fill_done_o,
  output logic [TAG_W-1:0]   fill_tag_o,
  output logic               fill_error_o,
  tcache_refill_if.master    tl
`ifdef TCACHE_REFILL_PERF_EN
  ,
  output logic [PERF_W-1:0]  perf_refills_o,
  output logic [PERF_W-1:0]  perf_stall_o
`endif
);

  state_e             state_q;
  logic [ADDR_W-1:0]  line_q;
  logic [INDEX_W-1:0] set_q;
  logic [TAG_W-1:0]   tag_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q;
  logic               miss_ready_q;
  logic               a_valid_q;
  logic               d_ready_q;
  logic               done_q;
  logic               done_err_q;

  logic a_fire_c;
  logic d_fire_c;
  logic beat_err_c;
  logic last_beat_c;
  logic unused_c;

  assign a_fire_c    = a_valid_q & tl.tcache_a_ready;
  assign d_fire_c    = d_ready_q & tl.tcache_d_valid;
  assign beat_err_c  = tl.tcache_d_denied | tl.tcache_d_corrupt |
                       (tl.tcache_d_opcode != TL_ACCESS_ACK_DATA);
  assign last_beat_c = (cnt_q == CNT_W'(LINE_WORDS - 1));
  assign unused_c    = ^{miss_addr_i[LINE_OFF_W-1:0], tl.tcache_d_param, tl.tcache_d_size};

  // Refill sequencer; handshake strobes are registered alongside the state.
  always_ff @(posedge core_clock_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) begin
      state_q      <= IDLE;
      line_q       <= '0;
      set_q        <= '0;
      tag_q        <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      miss_ready_q <= 1'b1;
      a_valid_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      done_q       <= 1'b0;
      done_err_q   <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (miss_valid_i) begin
            line_q       <= {miss_addr_i[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
            set_q        <= miss_addr_i[LINE_OFF_W +: INDEX_W];
            tag_q        <= miss_addr_i[LINE_OFF_W+INDEX_W +: TAG_W];
            cnt_q        <= '0;
            err_q        <= 1'b0;
            miss_ready_q <= 1'b0;
            a_valid_q    <= 1'b1;
            state_q      <= REQ;
          end
        end
        REQ: begin
          if (a_fire_c) begin
            a_valid_q <= 1'b0;
            d_ready_q <= 1'b1;
            state_q   <= RESP;
          end
        end
        RESP: begin
          if (d_fire_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
            err_q <= err_q | beat_err_c;
            if (last_beat_c) begin
              d_ready_q  <= 1'b0;
              done_q     <= 1'b1;
              done_err_q <= err_q | beat_err_c;
              state_q    <= DONE;
            end
          end
        end
        DONE: begin
          miss_ready_q <= 1'b1;
          state_q      <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign miss_ready_o = miss_ready_q;
  assign fill_we_o    = d_fire_c;
  assign fill_set_o   = set_q;
  assign fill_word_o  = cnt_q;
  assign fill_data_o  = d_fire_c ? tl.tcache_d_data : '0;
  assign fill_done_o  = done_q;
  assign fill_tag_o   = tag_q;
  assign fill_error_o = done_err_q;

  // A channel only ever carries a full-line Get.
  assign tl.tcache_a_opcode  = TL_GET;
  assign tl.tcache_a_param   = 3'd0;
  assign tl.tcache_a_size    = LINE_SIZE_LOG2;
  assign tl.tcache_a_address = line_q;
  assign tl.tcache_a_mask    = 4'hF;
  assign tl.tcache_a_data    = '0;
  assign tl.tcache_a_corrupt = 1'b0;
  assign tl.tcache_a_valid   = a_valid_q;
  assign tl.tcache_d_ready   = d_ready_q;

`ifdef TCACHE_REFILL_PERF_EN
  logic [PERF_W-1:0] refills_q;
  logic [PERF_W-1:0] stall_q;
  logic              stall_c;

  assign stall_c = ((state_q == REQ)  & ~tl.tcache_a_ready) |
                   ((state_q == RESP) & ~tl.tcache_d_valid);

  // Saturating refill and fabric-stall counters.
  always_ff @(posedge core_clock_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) begin
      refills_q <= '0;
      stall_q   <= '0;
    end else begin
      if (done_q && (refills_q != '1)) begin
        refills_q <= refills_q + PERF_W'(1);
      end
      if (stall_c && (stall_q != '1)) begin
        stall_q <= stall_q + PERF_W'(1);
      end
    end
  end

  assign perf_refills_o = refills_q;
  assign perf_stall_o   = stall_q;
`endif

endmodule
